// File: rtl/gpio_disp_pkg.sv
// Shared types and constants for the GPIO 7-segment display driver.
package gpio_disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int N_DIGITS   = 8;
   localparam int BCD_DIGITS = 10;
   localparam int CONV_ITERS = 32;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low gfedcba codes for hex digits 0..F
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more,
   // so the following left shift carries correctly into the next decade.
   function automatic logic [4*BCD_DIGITS-1:0] dd_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
      logic [4*BCD_DIGITS-1:0] r;
      r = bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/gpio_display_driver_if.sv
// CPU-side GPIO word in, 8-digit 7-segment bus and status out.
interface gpio_display_driver_if;
   import gpio_disp_pkg::*;

   logic [31:0]           value;
   logic                  dec_mode;
   logic [7*N_DIGITS-1:0] hex_seg;
   logic                  busy;
   logic                  ovf;

   modport master (
      output value,
      output dec_mode,
      input  hex_seg,
      input  busy,
      input  ovf
   );

   modport slave (
      input  value,
      input  dec_mode,
      output hex_seg,
      output busy,
      output ovf
   );

endinterface

// File: rtl/hex_to_7seg.sv
// One 4-bit nibble to one active-low gfedcba segment pattern.
module hex_to_7seg
   import gpio_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Pure lookup, no state
   always_comb begin
      seg_n = SEG_BLANK;
      case (nibble)
         4'h0: seg_n = SEG_0;
         4'h1: seg_n = SEG_1;
         4'h2: seg_n = SEG_2;
         4'h3: seg_n = SEG_3;
         4'h4: seg_n = SEG_4;
         4'h5: seg_n = SEG_5;
         4'h6: seg_n = SEG_6;
         4'h7: seg_n = SEG_7;
         4'h8: seg_n = SEG_8;
         4'h9: seg_n = SEG_9;
         4'hA: seg_n = SEG_A;
         4'hB: seg_n = SEG_B;
         4'hC: seg_n = SEG_C;
         4'hD: seg_n = SEG_D;
         4'hE: seg_n = SEG_E;
         4'hF: seg_n = SEG_F;
      endcase
   end

endmodule

// File: rtl/gpio_display_driver.sv
// Drives eight 7-segment digits from a CPU GPIO word, in hex or in unsigned
// decimal (serial double-dabble, one bit per clock).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | display stable; reload when inputs differ from the last load
//   CONV  | decimal conversion, one double-dabble iteration per edge
//   DONE  | register segments/ovf from bin (hex) or bcd (decimal)
module gpio_display_driver
   import gpio_disp_pkg::*;
#(
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gpio_display_driver_if.slave bus
);

   state_e                    state_q, state_d;
   logic [31:0]               last_val_q, last_val_d;
   logic                      last_mode_q, last_mode_d;
   logic                      first_pending_q, first_pending_d;
   logic [31:0]               bin_q, bin_d;
   logic [4*BCD_DIGITS-1:0]   bcd_q, bcd_d;
   logic [4:0]                cnt_q, cnt_d;
   logic                      busy_q, busy_d;
   logic                      ovf_q, ovf_d;
   logic [7*N_DIGITS-1:0]     hex_seg_q, hex_seg_d;

   logic [4*N_DIGITS-1:0]     disp_nib;
   logic [7*N_DIGITS-1:0]     seg_raw;
   logic [7*N_DIGITS-1:0]     seg_disp;
   logic [4*BCD_DIGITS-1:0]   bcd_adj;
   logic                      dec_ovf;
   logic                      lead;
   logic                      load_req;

   // In hex mode bin still holds the latched value; in decimal mode it has
   // been shifted out and the digits live in bcd.
   assign disp_nib = last_mode_q ? bcd_q[4*N_DIGITS-1:0] : bin_q;

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_seg
      hex_to_7seg u_seg (
         .nibble (disp_nib[4*g +: 4]),
         .seg_n  (seg_raw[7*g +: 7])
      );
   end

   // Leading-zero blanking; digit 0 is never blanked so zero reads "0"
   always_comb begin
      seg_disp = seg_raw;
      dec_ovf  = |bcd_q[4*BCD_DIGITS-1:4*N_DIGITS];
      lead     = 1'b1;
      if (BLANK_LEADING && last_mode_q && !dec_ovf) begin
         for (int i = N_DIGITS-1; i > 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
               lead = 1'b0;
            end
            if (lead) begin
               seg_disp[7*i +: 7] = SEG_BLANK;
            end
         end
      end
   end

   assign load_req = first_pending_q || (bus.value != last_val_q) ||
                     (bus.dec_mode != last_mode_q);

   // Next-state and datapath updates; everything holds unless a state acts
   always_comb begin
      state_d         = state_q;
      last_val_d      = last_val_q;
      last_mode_d     = last_mode_q;
      first_pending_d = first_pending_q;
      bin_d           = bin_q;
      bcd_d           = bcd_q;
      cnt_d           = cnt_q;
      busy_d          = busy_q;
      ovf_d           = ovf_q;
      hex_seg_d       = hex_seg_q;
      bcd_adj         = '0;
      unique case (state_q)
         IDLE: begin
            if (load_req) begin
               last_val_d      = bus.value;
               bin_d           = bus.value;
               last_mode_d     = bus.dec_mode;
               first_pending_d = 1'b0;
               bcd_d           = '0;
               cnt_d           = '0;
               if (bus.dec_mode) begin
                  busy_d  = 1'b1;
                  state_d = CONV;
               end else begin
                  state_d = DONE;
               end
            end
         end
         CONV: begin
            bcd_adj        = dd_adjust(bcd_q);
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'(CONV_ITERS-1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            hex_seg_d = seg_disp;
            ovf_d     = last_mode_q & dec_ovf;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         last_val_q      <= '0;
         last_mode_q     <= 1'b0;
         first_pending_q <= 1'b1;
         bin_q           <= '0;
         bcd_q           <= '0;
         cnt_q           <= '0;
         busy_q          <= 1'b0;
         ovf_q           <= 1'b0;
         hex_seg_q       <= {N_DIGITS{SEG_BLANK}};
      end else begin
         state_q         <= state_d;
         last_val_q      <= last_val_d;
         last_mode_q     <= last_mode_d;
         first_pending_q <= first_pending_d;
         bin_q           <= bin_d;
         bcd_q           <= bcd_d;
         cnt_q           <= cnt_d;
         busy_q          <= busy_d;
         ovf_q           <= ovf_d;
         hex_seg_q       <= hex_seg_d;
      end
   end

   assign bus.hex_seg = hex_seg_q;
   assign bus.busy    = busy_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_gpio_display_driver.sv
// Self-checking bench for gpio_display_driver: directed table, hand-written
// multi-cycle sequences and random values against a decimal/hex model.
module tb_gpio_display_driver;

   localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

   typedef struct {
      logic [31:0] value;
      logic        dec_mode;
      logic [55:0] exp_seg;
      logic        exp_ovf;
      string       name;
   } vec_t;

   logic clk;
   logic rst_n;

   gpio_display_driver_if bus();

   gpio_display_driver #(.BLANK_LEADING(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   vec_t        vecs[$];

   // Model of what the display should currently show
   bit          m_first;
   logic [31:0] m_last_val;
   logic        m_last_mode;
   logic [55:0] cur_seg;
   logic        cur_ovf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] s;
      case (d)
         0: s = 7'h40;  1: s = 7'h79;  2: s = 7'h24;  3: s = 7'h30;
         4: s = 7'h19;  5: s = 7'h12;  6: s = 7'h02;  7: s = 7'h78;
         8: s = 7'h00;  9: s = 7'h10; 10: s = 7'h08; 11: s = 7'h03;
        12: s = 7'h46; 13: s = 7'h21; 14: s = 7'h06; default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Display from first principles: hex nibbles, or decimal digits by division
   function automatic void ref_disp(input logic [31:0] v, input logic m,
                                    output logic [55:0] seg, output logic o);
      longint unsigned n;
      int dg[8];
      int top;
      seg = '0;
      o   = 1'b0;
      if (!m) begin
         for (int i = 0; i < 8; i++) seg[7*i +: 7] = seg_of(int'((v >> (4*i)) & 32'hF));
      end else begin
         n   = longint'(v);
         o   = (n > 64'd99999999);
         top = 0;
         for (int i = 0; i < 8; i++) begin
            dg[i] = int'(n % 10);
            n     = n / 10;
            if (dg[i] != 0) top = i;
         end
         for (int i = 0; i < 8; i++) begin
            if (!o && i > top) seg[7*i +: 7] = 7'h7F;
            else               seg[7*i +: 7] = seg_of(dg[i]);
         end
      end
   endfunction

   task automatic add_vec(input logic [31:0] v, input logic m, input logic [55:0] s,
                          input logic o, input string name);
      vec_t t;
      t.value = v; t.dec_mode = m; t.exp_seg = s; t.exp_ovf = o; t.name = name;
      vecs.push_back(t);
   endtask

   // Apply one settled input word just after an edge and check exact latency
   task automatic run_vec(input logic [31:0] v, input logic m, input logic [55:0] es,
                          input logic eo, input string tag);
      bit changed;
      changed = m_first || (v != m_last_val) || (m != m_last_mode);
      bus.value    = v;
      bus.dec_mode = m;
      if (!changed) begin
         repeat (3) tick();
         chk({tag, "/hold_seg"}, 64'(bus.hex_seg), 64'(cur_seg));
         chk({tag, "/hold_ovf"}, 64'(bus.ovf), 64'(cur_ovf));
         chk({tag, "/hold_busy"}, 64'(bus.busy), 64'(0));
      end else if (!m) begin
         tick();
         chk({tag, "/e0_seg"}, 64'(bus.hex_seg), 64'(cur_seg));
         chk({tag, "/e0_busy"}, 64'(bus.busy), 64'(0));
         tick();
         chk({tag, "/seg"}, 64'(bus.hex_seg), 64'(es));
         chk({tag, "/ovf"}, 64'(bus.ovf), 64'(eo));
         chk({tag, "/busy"}, 64'(bus.busy), 64'(0));
      end else begin
         for (int k = 0; k <= 32; k++) begin
            tick();
            chk({tag, "/conv_busy"}, 64'(bus.busy), 64'(1));
            if (k == 0 || k == 32) chk({tag, "/conv_seg"}, 64'(bus.hex_seg), 64'(cur_seg));
         end
         tick();
         chk({tag, "/seg"}, 64'(bus.hex_seg), 64'(es));
         chk({tag, "/ovf"}, 64'(bus.ovf), 64'(eo));
         chk({tag, "/busy"}, 64'(bus.busy), 64'(0));
      end
      if (changed) begin
         m_first     = 1'b0;
         m_last_val  = v;
         m_last_mode = m;
         cur_seg     = es;
         cur_ovf     = eo;
      end
   endtask

   initial begin
      logic [55:0] rs;
      logic        ro;
      logic [31:0] rv;
      logic        rm;

      clk          = 1'b0;
      rst_n        = 1'b0;
      bus.value    = 32'h0;
      bus.dec_mode = 1'b0;

      add_vec(32'hDEADBEEF, 1'b0, {7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E}, 1'b0, "hex_deadbeef");
      add_vec(32'h12345678, 1'b0, {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78,7'h00}, 1'b0, "hex_12345678");
      add_vec(32'hFFFFFFFF, 1'b1, {7'h10,7'h19,7'h10,7'h02,7'h78,7'h24,7'h10,7'h12}, 1'b1, "dec_max");
      add_vec(32'd99999999, 1'b1, {8{7'h10}}, 1'b0, "dec_99999999");
      add_vec(32'd100000000, 1'b1, {8{7'h40}}, 1'b1, "dec_1e8");
      add_vec(32'd0, 1'b1, {{7{7'h7F}}, 7'h40}, 1'b0, "dec_zero");
      add_vec(32'd0, 1'b0, {8{7'h40}}, 1'b0, "hex_zero");
      add_vec(32'd1234, 1'b1, {{4{7'h7F}}, 7'h79,7'h24,7'h30,7'h19}, 1'b0, "dec_1234");
      add_vec(32'd10000000, 1'b1, {7'h79, {7{7'h40}}}, 1'b0, "dec_1e7");
      add_vec(32'd1000, 1'b1, {{4{7'h7F}}, 7'h79,7'h40,7'h40,7'h40}, 1'b0, "dec_1000");
      add_vec(32'h00C0FFEE, 1'b0, {7'h40,7'h40,7'h46,7'h40,7'h0E,7'h0E,7'h06,7'h06}, 1'b0, "hex_c0ffee");
      add_vec(32'hFFFFFFFF, 1'b0, {8{7'h0E}}, 1'b0, "hex_ffffffff");
      add_vec(32'hFFFFFFFF, 1'b0, {8{7'h0E}}, 1'b0, "hex_repeat");

      repeat (3) tick();
      chk("reset_seg", 64'(bus.hex_seg), 64'(ALL_BLANK));
      chk("reset_busy", 64'(bus.busy), 64'(0));
      chk("reset_ovf", 64'(bus.ovf), 64'(0));
      m_first = 1'b1; m_last_val = '0; m_last_mode = 1'b0;
      cur_seg = ALL_BLANK; cur_ovf = 1'b0;

      rst_n = 1'b1;
      run_vec(32'h11, 1'b1, {{6{7'h7F}}, 7'h79, 7'h78}, 1'b0, "dec_17");

      foreach (vecs[i]) run_vec(vecs[i].value, vecs[i].dec_mode, vecs[i].exp_seg,
                                vecs[i].exp_ovf, vecs[i].name);

      // Input changes mid-conversion: first result shown, then the new value
      bus.value = 32'd5; bus.dec_mode = 1'b1;
      tick();
      chk("chg/e0_busy", 64'(bus.busy), 64'(1));
      repeat (10) tick();
      bus.value = 32'd12;
      repeat (22) tick();
      chk("chg/e32_busy", 64'(bus.busy), 64'(1));
      chk("chg/e32_seg", 64'(bus.hex_seg), 64'(cur_seg));
      tick();
      chk("chg/five_seg", 64'(bus.hex_seg), 64'({{7{7'h7F}}, 7'h12}));
      chk("chg/five_busy", 64'(bus.busy), 64'(0));
      tick();
      chk("chg/second_busy", 64'(bus.busy), 64'(1));
      chk("chg/second_seg_hold", 64'(bus.hex_seg), 64'({{7{7'h7F}}, 7'h12}));
      repeat (32) tick();
      chk("chg/second_busy_end", 64'(bus.busy), 64'(1));
      tick();
      chk("chg/twelve_seg", 64'(bus.hex_seg), 64'({{6{7'h7F}}, 7'h79, 7'h24}));
      chk("chg/twelve_busy", 64'(bus.busy), 64'(0));
      m_last_val = 32'd12; m_last_mode = 1'b1;
      cur_seg = {{6{7'h7F}}, 7'h79, 7'h24}; cur_ovf = 1'b0;

      // Reset in the middle of a conversion, then reconversion of the same input
      bus.value = 32'd87654321;
      tick();
      repeat (16) tick();
      rst_n = 1'b0;
      tick();
      chk("abort/busy", 64'(bus.busy), 64'(0));
      chk("abort/seg", 64'(bus.hex_seg), 64'(ALL_BLANK));
      chk("abort/ovf", 64'(bus.ovf), 64'(0));
      rst_n = 1'b1;
      m_first = 1'b1; m_last_val = '0; m_last_mode = 1'b0;
      cur_seg = ALL_BLANK; cur_ovf = 1'b0;
      run_vec(32'd87654321, 1'b1, {7'h00,7'h78,7'h02,7'h12,7'h19,7'h30,7'h24,7'h79}, 1'b0, "reconv");

      for (int r = 0; r < 24; r++) begin
         case ($urandom_range(0, 3))
            0:       rv = $urandom;
            1:       rv = $urandom_range(0, 999);
            2:       rv = $urandom_range(99999990, 100000010);
            default: rv = m_last_val;
         endcase
         rm = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) rm = m_last_mode;
         ref_disp(rv, rm, rs, ro);
         run_vec(rv, rm, rs, ro, $sformatf("rand%0d_%h_%0d", r, rv, rm));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
